seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-pin 7-segment digits.
- Features:
  - hex decode 0-F with per-digit decimal point;
  - prescaled digit scanning;
  - tear-free double-buffered data load;
  - optional leading-zero blanking;
  - selectable segment/digit polarity.
- Sits between the temperature/measurement datapath and the board display pins.
- Replaces the per-digit combinational decoders.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (>=2).
- REFRESH_DIV, 50000: clk cycles each digit is lit (>=2).
- SEG_ACTIVE_LOW, 0: 1 = seg_led[7:0] inverted at the output.
- DIG_ACTIVE_LOW, 1: 1 = dig_sel active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scan running; 0 = display dark, scan frozen.
- load  in  1  single-cycle strobe; capture data_in/dp_in.
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg_led  out  9  [6:0] = segments g..a, [7] = dp, [8] reserved, always 0.
- dig_sel  out  NUM_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW).
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, digit index = 0, display and pending registers = 0, pending_valid = 0, frame_done = 0.
  - seg_led = all segments off at the configured polarity, bit 8 = 0.
  - dig_sel = all inactive.
  - Reset mid-frame discards pending data.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable = 1.
  - tick asserts in the cycle count == REFRESH_DIV-1; count then wraps to 0.
- Digit index:
  - Advances on tick.
  - Wraps from NUM_DIGITS-1 to 0; the wrapping tick is the frame boundary.
  - frame_done is registered and is high in the cycle after the boundary tick.
- Load:
  - load = 1 writes data_in/dp_in to the pending register and sets pending_valid.
  - A second load before the boundary overwrites the pending data (last wins).
- Commit at frame boundary:
  - If pending_valid, display <= pending and pending_valid clears.
  - If load coincides with the boundary, data_in/dp_in commit directly to display and pending_valid = 0.
  - The display register never changes mid-frame.
- Decode table, hex 0-F -> [6:0]: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero blanking (blank_lz = 1):
  - Digit k (k >= 1) is blanked if its nibble and all more significant nibbles are 0.
  - Blanked digit shows [6:0] off; dp still follows dp_in.
  - Digit 0 is never blanked.
  - blank_lz is sampled combinationally against the display register.
- Outputs:
  - Registered, one cycle after the index/display state they reflect.
  - The active digit's dig_sel bit is asserted, all others inactive.
  - Polarity inversion is applied last.
- enable = 0:
  - Prescaler and index hold.
  - Outputs go to off/inactive on the next clk.
  - load and commit still function; a pending commit waits for the next boundary.
  - Re-enable resumes from the held count.

Decomposition:
- Package seg7_pkg holds:
  - SEG_W = 9;
  - the 16-entry segment constant table;
  - the blank-pattern constant.
- Sub-module seg7_hex_lut: combinational nibble + dp + blank -> 9-bit pattern, instantiated once on the muxed digit.
- Top module holds the prescaler, index counter, double buffer, blanking logic and output registers.

Test Plan (NUM_DIGITS = 4, REFRESH_DIV = 4, SEG_ACTIVE_LOW = 0, DIG_ACTIVE_LOW = 1):
- Scan order: reset, enable = 1, load data_in = 16'h1234, dp_in = 0 at the boundary -> one frame later dig_sel cycles 1110, 1101, 1011, 0111, 4 cycles each; seg_led = 0x66, 0x4F, 0x5B, 0x06; frame_done pulses every 16 cycles.
- Tear-free load: load 16'hABCD mid-frame while 16'h1234 is shown -> remaining digits still show 1234 segments; from the next frame seg_led = 0x5E, 0x39, 0x7C, 0x77; two loads mid-frame -> only the second appears.
- Leading-zero blanking: blank_lz = 1, data 16'h0050, dp_in = 4'b1000 -> digit 3 seg_led = 0x080, digit 2 = 0x000, digit 1 = 0x6D, digit 0 = 0x3F; data 16'h0000 -> only digit 0 lit, 0x3F.
- Enable control: enable = 0 mid-slot -> next cycle dig_sel = 1111, seg_led = 0; re-enable -> same digit resumes and completes its remaining count.
- Reset mid-frame: assert rst_n = 0 asynchronously mid-frame with a pending load -> outputs immediately off/inactive; after release the display shows 0 (0x3F on digit 0, blank_lz = 0 -> all 0x3F) and the pending data is lost.
- Polarity: SEG_ACTIVE_LOW = 1, DIG_ACTIVE_LOW = 0 -> digit 0 showing 8 with dp gives seg_led = 0x000, dig_sel = 0001; reset value seg_led = 0x0FF.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: pattern width, the
// hex-to-segment table and the all-off pattern.
package seg7_pkg;

    // Output pattern width: [6:0] segments g..a, [7] dp, [8] reserved.
    localparam int SEG_W = 9;

    // Hex 0-F to segments g..a, active-high. Packed so entry k is SEG_TABLE[k];
    // the literal lists entry F first because packed arrays fill MSB first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Active-high "nothing lit" pattern, before polarity is applied.
    localparam logic [SEG_W-1:0] SEG_BLANK = 9'h000;

    // Bits flipped when the segment pins are active-low; bit 8 stays 0.
    localparam logic [SEG_W-1:0] SEG_INV_MASK = 9'h0FF;

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational decode of one hex nibble plus decimal point into the
// active-high 9-bit segment pattern. Blanking darkens the digit segments
// only; the decimal point always follows dp.
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             dp,
    input  logic             blank,
    output logic [SEG_W-1:0] pattern
);

    // Table lookup with blanking override on the digit segments.
    always_comb begin
        pattern = {1'b0, dp, (blank ? 7'h00 : SEG_TABLE[nibble])};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-pin 7-segment digits.
// A prescaler sets how long each digit is lit; the digit index walks
// 0..NUM_DIGITS-1 and its wrap marks the frame boundary. New data lands in
// a pending buffer and is only copied to the displayed buffer at the frame
// boundary, so a frame never mixes old and new digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [SEG_W-1:0]        seg_led,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Pin-level "off" values after polarity.
    localparam logic [SEG_W-1:0]      SEG_POL = SEG_ACTIVE_LOW ? SEG_INV_MASK : '0;
    localparam logic [SEG_W-1:0]      SEG_OFF = SEG_BLANK ^ SEG_POL;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_POL;

    // Scan state.
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             boundary;

    // Double buffer.
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;

    // Current-digit selection and decode.
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [SEG_W-1:0]      cur_pattern;
    logic                  zero_run;

    assign tick     = enable && (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Prescaler: counts the cycles of the current digit slot, frozen when disabled.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Digit index: advances once per slot and wraps at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Double buffer: loads go to pending; display only changes at the boundary.
    // A load on the boundary itself goes straight to the display.
    // NOTE: the display buffer is reset, unlike a plain data RAM, because
    // its reset contents are visible on the pins right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data  <= '0;
            disp_dp    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp_data  <= data_in;
                disp_dp    <= dp_in;
                pend_valid <= 1'b0;
            end else if (pend_valid) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
            end
        end else if (load) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_valid <= 1'b1;
        end
    end

    // Leading-zero mask: digit k blanks when it and everything above it is zero.
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (disp_data[4*k +: 4] == 4'h0);
            blank_vec[k] = blank_lz && zero_run;
        end
    end

    // Select the nibble, dp and blank flag of the digit currently scanned.
    always_comb begin
        onehot     = '0;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                onehot[k]  = 1'b1;
                cur_nibble = disp_data[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_blank  = blank_vec[k];
            end
        end
    end

    seg7_hex_lut u_lut (
        .nibble  (cur_nibble),
        .dp      (cur_dp),
        .blank   (cur_blank),
        .pattern (cur_pattern)
    );

    // Output registers: decoded digit with polarity applied last, dark when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_led <= SEG_OFF;
            dig_sel <= DIG_OFF;
        end else if (enable) begin
            seg_led <= cur_pattern ^ SEG_POL;
            dig_sel <= onehot ^ DIG_POL;
        end else begin
            seg_led <= SEG_OFF;
            dig_sel <= DIG_OFF;
        end
    end

    // Frame pulse: high for the cycle after the boundary tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scan order, tear-free loading,
// leading-zero blanking, enable control, mid-frame reset and polarity.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;

    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [8:0]  seg_led;
    logic [3:0]  dig_sel;
    logic        frame_done;

    logic        pol_enable;
    logic        pol_load;
    logic [15:0] pol_data;
    logic [3:0]  pol_dp;
    logic [8:0]  pol_seg;
    logic [3:0]  pol_dig;
    logic        pol_fd;

    int checks;
    int errors;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg_led    (seg_led),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b0)
    ) u_pol (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (pol_enable),
        .load       (pol_load),
        .data_in    (pol_data),
        .dp_in      (pol_dp),
        .blank_lz   (1'b0),
        .seg_led    (pol_seg),
        .dig_sel    (pol_dig),
        .frame_done (pol_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // n cycles of digit d on the main instance; frame_done expected on the last one if fd_last.
    task automatic check_cycles(input int d, input logic [8:0] seg, input int n, input bit fd_last);
        logic [3:0] exp_dig;
        exp_dig    = 4'b1111;
        exp_dig[d] = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("dig_sel d%0d c%0d", d, c), 32'(dig_sel), 32'(exp_dig));
            check($sformatf("seg_led d%0d c%0d", d, c), 32'(seg_led), 32'(seg));
            check($sformatf("frame_done d%0d c%0d", d, c), 32'(frame_done),
                  32'(fd_last && (c == n - 1)));
            load = 1'b0;
        end
    endtask

    task automatic check_frame(input logic [8:0] s0, input logic [8:0] s1,
                               input logic [8:0] s2, input logic [8:0] s3);
        check_cycles(0, s0, 4, 1'b0);
        check_cycles(1, s1, 4, 1'b0);
        check_cycles(2, s2, 4, 1'b0);
        check_cycles(3, s3, 4, 1'b1);
    endtask

    task automatic check_off(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("off dig_sel", 32'(dig_sel), 32'h0000_000F);
            check("off seg_led", 32'(seg_led), 32'h0000_0000);
            check("off frame_done", 32'(frame_done), 32'h0);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        data_in    = '0;
        dp_in      = '0;
        blank_lz   = 1'b0;
        pol_enable = 1'b0;
        pol_load   = 1'b0;
        pol_data   = '0;
        pol_dp     = '0;

        // Reset values on both polarity configurations.
        @(negedge clk);
        check("rst seg_led", 32'(seg_led), 32'h000);
        check("rst dig_sel", 32'(dig_sel), 32'hF);
        check("rst frame_done", 32'(frame_done), 32'h0);
        check("rst pol seg_led", 32'(pol_seg), 32'h0FF);
        check("rst pol dig_sel", 32'(pol_dig), 32'h0);

        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // First frame shows zeros; load 1234 on the boundary cycle itself.
        check_cycles(0, 9'h03F, 4, 1'b0);
        check_cycles(1, 9'h03F, 4, 1'b0);
        check_cycles(2, 9'h03F, 4, 1'b0);
        check_cycles(3, 9'h03F, 3, 1'b0);
        do_load(16'h1234, 4'b0000);
        check_cycles(3, 9'h03F, 1, 1'b1);

        // Scan order: digit 0 first, 4 cycles each.
        check_frame(9'h066, 9'h04F, 9'h05B, 9'h006);

        // Mid-frame load does not tear the current frame.
        check_cycles(0, 9'h066, 4, 1'b0);
        do_load(16'hABCD, 4'b0000);
        check_cycles(1, 9'h04F, 4, 1'b0);
        check_cycles(2, 9'h05B, 4, 1'b0);
        check_cycles(3, 9'h006, 4, 1'b1);

        // ABCD appears; two loads in this frame, only the second survives.
        check_cycles(0, 9'h05E, 4, 1'b0);
        do_load(16'h1111, 4'b0000);
        check_cycles(1, 9'h039, 4, 1'b0);
        do_load(16'h0050, 4'b1000);
        check_cycles(2, 9'h07C, 4, 1'b0);
        check_cycles(3, 9'h077, 4, 1'b1);

        // 0050 without blanking.
        check_frame(9'h03F, 9'h06D, 9'h03F, 9'h0BF);

        // Leading-zero blanking: digit 3 keeps its dp, digit 2 dark.
        blank_lz = 1'b1;
        check_cycles(0, 9'h03F, 4, 1'b0);
        do_load(16'h0000, 4'b0000);
        check_cycles(1, 9'h06D, 4, 1'b0);
        check_cycles(2, 9'h000, 4, 1'b0);
        check_cycles(3, 9'h080, 4, 1'b1);

        // All-zero value: only digit 0 lit.
        check_frame(9'h03F, 9'h000, 9'h000, 9'h000);

        // Enable dropped mid-slot of digit 1, then resumed.
        blank_lz = 1'b0;
        check_cycles(0, 9'h03F, 4, 1'b0);
        check_cycles(1, 9'h03F, 2, 1'b0);
        enable = 1'b0;
        check_off(5);
        enable = 1'b1;
        check_cycles(1, 9'h03F, 2, 1'b0);
        check_cycles(2, 9'h03F, 4, 1'b0);
        check_cycles(3, 9'h03F, 4, 1'b1);

        // Asynchronous reset mid-frame with a pending load.
        do_load(16'h1234, 4'b1111);
        check_cycles(0, 9'h03F, 4, 1'b0);
        check_cycles(1, 9'h03F, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst seg_led", 32'(seg_led), 32'h000);
        check("async rst dig_sel", 32'(dig_sel), 32'hF);
        check("async rst frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(9'h03F, 9'h03F, 9'h03F, 9'h03F);
        check_frame(9'h03F, 9'h03F, 9'h03F, 9'h03F);

        // Inverted polarities: 8 with dp on digit 0.
        pol_data   = 16'h0008;
        pol_dp     = 4'b0001;
        pol_load   = 1'b1;
        pol_enable = 1'b1;
        @(negedge clk);
        pol_load = 1'b0;
        check("pol seg first frame d0", 32'(pol_seg), 32'h0C0);
        check("pol dig first frame d0", 32'(pol_dig), 32'h1);
        repeat (15) @(negedge clk);
        check("pol seg first frame d3", 32'(pol_seg), 32'h0C0);
        check("pol dig first frame d3", 32'(pol_dig), 32'h8);
        check("pol frame_done", 32'(pol_fd), 32'h1);
        @(negedge clk);
        check("pol seg 8 dp", 32'(pol_seg), 32'h000);
        check("pol dig d0", 32'(pol_dig), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
